// File: rtl/otter_csr_irq.sv
// Machine-mode CSR unit for the OTTER core: Zicsr access, multi-line interrupt
// prioritisation, trap/MRET state changes, 64-bit counters and next-PC target.
module otter_csr_irq #(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ext_intrpt,
    input  logic [NUM_IRQ-1:0] i_plat_irq,
    input  logic [2:0]         i_op,
    input  logic [1:0]         i_funct3_low,
    input  logic               i_w_en,
    input  logic [11:0]        i_addr,
    input  logic [31:0]        i_pc_addr,
    input  logic [31:0]        i_w_data,
    input  logic               i_instr_ret,
    input  logic [31:0]        i_trap_val,
    output logic [31:0]        o_r_data,
    output logic               o_addr_vld,
    output logic               o_read_only,
    output logic               o_intrpt_vld,
    output logic [4:0]         o_intrpt_cause,
    output logic [31:0]        o_trap_pc
);

    localparam logic [2:0] OP_WRITE  = 3'd0;
    localparam logic [2:0] OP_ECALL  = 3'd1;
    localparam logic [2:0] OP_EBREAK = 3'd2;
    localparam logic [2:0] OP_MRET   = 3'd3;
    localparam logic [2:0] OP_INTRPT = 3'd4;
    localparam logic [2:0] OP_TRAP   = 3'd5;
    localparam logic [2:0] OP_WFI    = 3'd6;

    localparam logic [11:0] A_MSTATUS    = 12'h300;
    localparam logic [11:0] A_MISA       = 12'h301;
    localparam logic [11:0] A_MIE        = 12'h304;
    localparam logic [11:0] A_MTVEC      = 12'h305;
    localparam logic [11:0] A_MCOUNTINH  = 12'h320;
    localparam logic [11:0] A_MSCRATCH   = 12'h340;
    localparam logic [11:0] A_MEPC       = 12'h341;
    localparam logic [11:0] A_MCAUSE     = 12'h342;
    localparam logic [11:0] A_MTVAL      = 12'h343;
    localparam logic [11:0] A_MIP        = 12'h344;
    localparam logic [11:0] A_MCYCLE     = 12'hB00;
    localparam logic [11:0] A_MINSTRET   = 12'hB02;
    localparam logic [11:0] A_MCYCLEH    = 12'hB80;
    localparam logic [11:0] A_MINSTRETH  = 12'hB82;
    localparam logic [11:0] A_MVENDORID  = 12'hF11;
    localparam logic [11:0] A_MARCHID    = 12'hF12;
    localparam logic [11:0] A_MIMPID     = 12'hF13;
    localparam logic [11:0] A_MHARTID    = 12'hF14;
    localparam logic [11:0] A_MCONFIGPTR = 12'hF15;

    localparam logic [31:0] MISA_VAL = 32'h4000_0100;
    localparam logic [31:0] MIE_MASK = 32'h0000_0800 | (((32'h1 << NUM_IRQ) - 32'h1) << 16);

    logic               r_mie_b;
    logic               r_mpie;
    logic [31:0]        r_mie;
    logic [31:0]        r_mtvec;
    logic [31:0]        r_mscratch;
    logic [31:0]        r_mepc;
    logic [31:0]        r_mcause;
    logic [31:0]        r_mtval;
    logic               r_inh_cy;
    logic               r_inh_ir;
    logic [63:0]        r_mcycle;
    logic [63:0]        r_minstret;
    logic               r_mip_ext;
    logic [NUM_IRQ-1:0] r_mip_plat;

    logic [31:0] w_mip;
    logic [31:0] w_pend;
    logic [4:0]  w_cause;
    logic        w_wr;
    logic [31:0] w_wval;
    logic [31:0] w_base;
    logic [31:0] w_trap_cause;

    function automatic logic [31:0] csr_wval(input logic [1:0]  funct,
                                             input logic [31:0] old_val,
                                             input logic [31:0] operand);
        case (funct)
            2'b01:   return operand;
            2'b10:   return old_val | operand;
            2'b11:   return old_val & ~operand;
            default: return old_val;
        endcase
    endfunction

    always_comb begin
        w_mip     = 32'd0;
        w_mip[11] = r_mip_ext;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_mip[16+i] = r_mip_plat[i];
        end
    end

    assign w_pend       = r_mie & w_mip;
    assign o_intrpt_vld = r_mie_b & (|w_pend);

    // Walk platform lines from the top down so the lowest-numbered one wins; MEIP overrides all.
    always_comb begin
        w_cause = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pend[16+i]) begin
                w_cause = 5'(16 + i);
            end
        end
        if (w_pend[11]) begin
            w_cause = 5'd11;
        end
    end

    assign o_intrpt_cause = w_cause;

    always_comb begin
        o_r_data    = 32'd0;
        o_addr_vld  = 1'b1;
        o_read_only = 1'b0;
        case (i_addr)
            A_MSTATUS:    o_r_data = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie_b, 3'd0};
            A_MISA:       o_r_data = MISA_VAL;
            A_MIE:        o_r_data = r_mie;
            A_MTVEC:      o_r_data = r_mtvec;
            A_MCOUNTINH:  o_r_data = {29'd0, r_inh_ir, 1'b0, r_inh_cy};
            A_MSCRATCH:   o_r_data = r_mscratch;
            A_MEPC:       o_r_data = r_mepc;
            A_MCAUSE:     o_r_data = r_mcause;
            A_MTVAL:      o_r_data = r_mtval;
            A_MIP:        o_r_data = w_mip;
            A_MCYCLE:     o_r_data = r_mcycle[31:0];
            A_MCYCLEH:    o_r_data = r_mcycle[63:32];
            A_MINSTRET:   o_r_data = r_minstret[31:0];
            A_MINSTRETH:  o_r_data = r_minstret[63:32];
            A_MVENDORID, A_MARCHID, A_MIMPID, A_MCONFIGPTR: begin
                o_read_only = 1'b1;
            end
            A_MHARTID: begin
                o_r_data    = HART_ID;
                o_read_only = 1'b1;
            end
            default: begin
                o_addr_vld  = 1'b0;
                o_read_only = 1'b1;
            end
        endcase
    end

    assign w_wr   = (i_op == OP_WRITE) && i_w_en && (i_funct3_low != 2'b00) &&
                    o_addr_vld && !o_read_only;
    assign w_wval = csr_wval(i_funct3_low, o_r_data, i_w_data);
    assign w_base = {r_mtvec[31:2], 2'b00};

    always_comb begin
        case (i_op)
            OP_ECALL:  w_trap_cause = 32'd11;
            OP_EBREAK: w_trap_cause = 32'd3;
            OP_TRAP:   w_trap_cause = 32'd2;
            default:   w_trap_cause = {1'b1, 26'd0, w_cause};
        endcase
    end

    always_comb begin
        case (i_op)
            OP_ECALL, OP_EBREAK, OP_TRAP: o_trap_pc = w_base;
            OP_INTRPT: begin
                if (r_mtvec[1:0] == 2'b01) begin
                    o_trap_pc = w_base + {25'd0, w_cause, 2'b00};
                end else begin
                    o_trap_pc = w_base;
                end
            end
            OP_MRET:   o_trap_pc = r_mepc;
            OP_WFI:    o_trap_pc = 32'd0;
            default:   o_trap_pc = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mie_b    <= 1'b0;
            r_mpie     <= 1'b0;
            r_mie      <= 32'd0;
            r_mtvec    <= 32'd0;
            r_mscratch <= 32'd0;
            r_mepc     <= 32'd0;
            r_mcause   <= 32'd0;
            r_mtval    <= 32'd0;
            r_inh_cy   <= 1'b0;
            r_inh_ir   <= 1'b0;
            r_mip_ext  <= 1'b0;
            r_mip_plat <= '0;
        end else begin
            r_mip_ext  <= i_ext_intrpt;
            r_mip_plat <= i_plat_irq;
            case (i_op)
                OP_ECALL, OP_EBREAK, OP_TRAP, OP_INTRPT: begin
                    r_mepc   <= i_pc_addr & ~32'h3;
                    r_mpie   <= r_mie_b;
                    r_mie_b  <= 1'b0;
                    r_mcause <= w_trap_cause;
                    r_mtval  <= (i_op == OP_TRAP) ? i_trap_val : 32'd0;
                end
                OP_MRET: begin
                    r_mie_b <= r_mpie;
                    r_mpie  <= 1'b1;
                end
                OP_WRITE: begin
                    if (w_wr) begin
                        case (i_addr)
                            A_MSTATUS: begin
                                r_mie_b <= w_wval[3];
                                r_mpie  <= w_wval[7];
                            end
                            A_MIE:       r_mie      <= w_wval & MIE_MASK;
                            A_MTVEC:     r_mtvec    <= {w_wval[31:2], 1'b0,
                                                        VECTORED_EN && (w_wval[1:0] == 2'b01)};
                            A_MSCRATCH:  r_mscratch <= w_wval;
                            A_MEPC:      r_mepc     <= w_wval & ~32'h3;
                            A_MCAUSE:    r_mcause   <= w_wval;
                            A_MTVAL:     r_mtval    <= w_wval;
                            A_MCOUNTINH: begin
                                r_inh_cy <= w_wval[0];
                                r_inh_ir <= w_wval[2];
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // A write to either half owns the counter for that cycle: no increment, no carry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            if (w_wr && (i_addr == A_MCYCLE)) begin
                r_mcycle[31:0] <= w_wval;
            end else if (w_wr && (i_addr == A_MCYCLEH)) begin
                r_mcycle[63:32] <= w_wval;
            end else if (!r_inh_cy) begin
                r_mcycle <= r_mcycle + 64'd1;
            end

            if (w_wr && (i_addr == A_MINSTRET)) begin
                r_minstret[31:0] <= w_wval;
            end else if (w_wr && (i_addr == A_MINSTRETH)) begin
                r_minstret[63:32] <= w_wval;
            end else if (!r_inh_ir && i_instr_ret) begin
                r_minstret <= r_minstret + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_otter_csr_irq.sv
// Randomised and directed bench for otter_csr_irq against a CSR-table reference model.
module tb_otter_csr_irq;

    localparam int          NIRQ = 4;
    localparam logic [31:0] HID  = 32'h0000_0005;
    localparam bit          VEC  = 1'b1;
    localparam logic [31:0] MIE_M = 32'h000F_0800;

    localparam logic [2:0] OP_WRITE  = 3'd0;
    localparam logic [2:0] OP_ECALL  = 3'd1;
    localparam logic [2:0] OP_EBREAK = 3'd2;
    localparam logic [2:0] OP_MRET   = 3'd3;
    localparam logic [2:0] OP_INTRPT = 3'd4;
    localparam logic [2:0] OP_TRAP   = 3'd5;
    localparam logic [2:0] OP_WFI    = 3'd6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ext = 1'b0;
    logic [NIRQ-1:0] plat = '0;
    logic [2:0]      op = OP_WRITE;
    logic [1:0]      f3 = 2'b00;
    logic            w_en = 1'b0;
    logic [11:0]     addr = 12'h000;
    logic [31:0]     pc = 32'd0;
    logic [31:0]     wd = 32'd0;
    logic            iret = 1'b0;
    logic [31:0]     tv = 32'd0;
    logic [31:0]     r_data;
    logic            addr_vld;
    logic            read_only;
    logic            intrpt_vld;
    logic [4:0]      intrpt_cause;
    logic [31:0]     trap_pc;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_reg [0:4095];
    logic [63:0] m_cyc;
    logic [63:0] m_ret;
    logic [31:0] m_mip;

    otter_csr_irq #(.NUM_IRQ(NIRQ), .HART_ID(HID), .VECTORED_EN(VEC)) dut (
        .i_clk(clk), .i_rst(rst), .i_ext_intrpt(ext), .i_plat_irq(plat),
        .i_op(op), .i_funct3_low(f3), .i_w_en(w_en), .i_addr(addr),
        .i_pc_addr(pc), .i_w_data(wd), .i_instr_ret(iret), .i_trap_val(tv),
        .o_r_data(r_data), .o_addr_vld(addr_vld), .o_read_only(read_only),
        .o_intrpt_vld(intrpt_vld), .o_intrpt_cause(intrpt_cause), .o_trap_pc(trap_pc)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 4096; i++) m_reg[i] = 32'd0;
        m_cyc = 64'd0;
        m_ret = 64'd0;
        m_mip = 32'd0;
    endfunction

    function automatic void mdl_read(input logic [11:0] a, output logic [31:0] v,
                                     output logic vld, output logic ro);
        v = 32'd0; vld = 1'b1; ro = 1'b0;
        case (a)
            12'h300: v = m_reg[a] | 32'h0000_1800;
            12'h301: v = 32'h4000_0100;
            12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342, 12'h343: v = m_reg[a];
            12'h344: v = m_mip;
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
            12'hB02: v = m_ret[31:0];
            12'hB82: v = m_ret[63:32];
            12'hF11, 12'hF12, 12'hF13, 12'hF15: ro = 1'b1;
            12'hF14: begin v = HID; ro = 1'b1; end
            default: begin vld = 1'b0; ro = 1'b1; end
        endcase
    endfunction

    // Priority order: MEIP, then platform line 0, 1, ...
    function automatic logic [4:0] mdl_cause();
        logic [31:0] p;
        p = m_reg[12'h304] & m_mip;
        if (p[11]) return 5'd11;
        for (int i = 0; i < NIRQ; i++) if (p[16+i]) return 5'(16 + i);
        return 5'd0;
    endfunction

    function automatic logic mdl_vld();
        return m_reg[12'h300][3] && ((m_reg[12'h304] & m_mip) != 32'd0);
    endfunction

    function automatic logic [31:0] mdl_tpc();
        logic [31:0] base;
        base = m_reg[12'h305] & 32'hFFFF_FFFC;
        case (op)
            OP_ECALL, OP_EBREAK, OP_TRAP: return base;
            OP_INTRPT: return (m_reg[12'h305][1:0] == 2'b01) ? base + 32'(mdl_cause()) * 4 : base;
            OP_MRET: return m_reg[12'h341];
            default: return 32'd0;
        endcase
    endfunction

    function automatic void mdl_step();
        logic [31:0] old, nv, inh;
        logic v, ro, cw, rw;
        logic [4:0] c;
        mdl_read(addr, old, v, ro);
        inh = m_reg[12'h320];
        c = mdl_cause();
        cw = 1'b0; rw = 1'b0;
        case (op)
            OP_WRITE: if (w_en && f3 != 2'b00 && v && !ro) begin
                nv = (f3 == 2'b01) ? wd : (f3 == 2'b10) ? (old | wd) : (old & ~wd);
                case (addr)
                    12'h300: m_reg[addr] = nv & 32'h88;
                    12'h304: m_reg[addr] = nv & MIE_M;
                    12'h305: m_reg[addr] = (nv & 32'hFFFF_FFFC) | ((VEC && nv[1:0] == 2'b01) ? 32'd1 : 32'd0);
                    12'h340, 12'h342, 12'h343: m_reg[addr] = nv;
                    12'h341: m_reg[addr] = nv & 32'hFFFF_FFFC;
                    12'h320: m_reg[addr] = nv & 32'h5;
                    12'hB00: begin m_cyc[31:0]  = nv; cw = 1'b1; end
                    12'hB80: begin m_cyc[63:32] = nv; cw = 1'b1; end
                    12'hB02: begin m_ret[31:0]  = nv; rw = 1'b1; end
                    12'hB82: begin m_ret[63:32] = nv; rw = 1'b1; end
                    default: ;
                endcase
            end
            OP_ECALL, OP_EBREAK, OP_TRAP, OP_INTRPT: begin
                m_reg[12'h341] = pc & 32'hFFFF_FFFC;
                m_reg[12'h300] = m_reg[12'h300][3] ? 32'h80 : 32'h0;
                m_reg[12'h342] = (op == OP_ECALL) ? 32'd11 : (op == OP_EBREAK) ? 32'd3 :
                                 (op == OP_TRAP) ? 32'd2 : (32'h8000_0000 | 32'(c));
                m_reg[12'h343] = (op == OP_TRAP) ? tv : 32'd0;
            end
            OP_MRET: m_reg[12'h300] = 32'h80 | (m_reg[12'h300][7] ? 32'h8 : 32'h0);
            default: ;
        endcase
        if (!cw && !inh[0]) m_cyc = m_cyc + 64'd1;
        if (!rw && !inh[2] && iret) m_ret = m_ret + 64'd1;
        m_mip = (32'(ext) << 11) | (32'(plat) << 16);
    endfunction

    task automatic setin(input logic [2:0] o, input logic [1:0] f, input logic we,
                         input logic [11:0] a, input logic [31:0] d,
                         input logic [31:0] p, input logic [31:0] t);
        op = o; f3 = f; w_en = we; addr = a; wd = d; pc = p; tv = t;
    endtask

    task automatic cyc();
        logic [31:0] ev;
        logic evl, ero;
        @(negedge clk);
        mdl_read(addr, ev, evl, ero);
        chk("r_data", r_data, ev);
        chk("addr_vld", 32'(addr_vld), 32'(evl));
        chk("read_only", 32'(read_only), 32'(ero));
        chk("intrpt_vld", 32'(intrpt_vld), 32'(mdl_vld()));
        chk("intrpt_cause", 32'(intrpt_cause), 32'(mdl_cause()));
        chk("trap_pc", trap_pc, mdl_tpc());
        @(posedge clk);
        mdl_step();
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        setin(OP_WRITE, 2'b01, 1'b1, a, d, 32'd0, 32'd0);
        cyc();
    endtask

    task automatic idle();
        setin(OP_WRITE, 2'b00, 1'b0, 12'h344, 32'd0, 32'd0, 32'd0);
        cyc();
    endtask

    task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
        op = OP_WRITE; w_en = 1'b0; addr = a;
        #1;
        chk(tag, r_data, exp);
    endtask

    logic [11:0] atab [0:21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'h320, 12'hB00, 12'hB80,
                                 12'hB02, 12'hB82, 12'hF11, 12'hF12, 12'hF13, 12'hF14,
                                 12'hF15, 12'h7C0, 12'h000, 12'h3A0};

    initial begin
        m_reset();
        #3;
        chk("rst_vld", 32'(intrpt_vld), 32'd0);
        chk("rst_cause", 32'(intrpt_cause), 32'd0);
        op = OP_ECALL;
        #1;
        chk("rst_tpc", trap_pc, 32'd0);
        peek("misa", 12'h301, 32'h4000_0100);
        chk("misa_ro", 32'(read_only), 32'd0);
        peek("hartid", 12'hF14, HID);
        chk("hartid_ro", 32'(read_only), 32'd1);
        peek("rst_mstatus", 12'h300, 32'h0000_1800);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        wr(12'h301, 32'hFFFF_FFFF);
        peek("misa_wr", 12'h301, 32'h4000_0100);

        wr(12'h300, 32'h8);
        wr(12'h304, 32'h0003_0800);
        plat = 4'b0010; ext = 1'b1;
        idle();
        chk("irq_vld", 32'(intrpt_vld), 32'd1);
        chk("irq_c11", 32'(intrpt_cause), 32'd11);
        peek("mip", 12'h344, 32'h0002_0800);
        ext = 1'b0;
        idle();
        chk("irq_c17", 32'(intrpt_cause), 32'd17);

        wr(12'h305, 32'h0000_1001);
        setin(OP_INTRPT, 2'b00, 1'b0, 12'h000, 32'd0, 32'h200, 32'd0);
        #1;
        chk("tpc_vec", trap_pc, 32'h0000_1044);
        cyc();
        peek("mepc", 12'h341, 32'h200);
        peek("mcause_irq", 12'h342, 32'h8000_0011);
        peek("mstatus_trap", 12'h300, 32'h0000_1880);
        setin(OP_MRET, 2'b00, 1'b0, 12'h000, 32'd0, 32'd0, 32'd0);
        #1;
        chk("tpc_mret", trap_pc, 32'h200);
        cyc();
        peek("mstatus_mret", 12'h300, 32'h0000_1888);

        setin(OP_TRAP, 2'b00, 1'b0, 12'h000, 32'd0, 32'h300, 32'hDEAD_BEEF);
        #1;
        chk("tpc_trap_vec", trap_pc, 32'h1000);
        cyc();
        peek("mcause_trap", 12'h342, 32'd2);
        peek("mtval", 12'h343, 32'hDEAD_BEEF);
        wr(12'h305, 32'h0000_1000);
        setin(OP_INTRPT, 2'b00, 1'b0, 12'h000, 32'd0, 32'h204, 32'd0);
        #1;
        chk("tpc_irq_direct", trap_pc, 32'h1000);
        setin(OP_TRAP, 2'b00, 1'b0, 12'h000, 32'd0, 32'h208, 32'h1234);
        #1;
        chk("tpc_trap_direct", trap_pc, 32'h1000);
        cyc();
        peek("mtval2", 12'h343, 32'h1234);

        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'd0);
        peek("cyc_lo_a", 12'hB00, 32'hFFFF_FFFF);
        peek("cyc_hi_a", 12'hB80, 32'd0);
        idle();
        peek("cyc_lo_b", 12'hB00, 32'd0);
        peek("cyc_hi_b", 12'hB80, 32'd1);
        wr(12'h320, 32'h1);
        peek("cy_lo_a", 12'hB00, 32'd1);
        idle();
        peek("cy_lo_b", 12'hB00, 32'd1);
        peek("cy_hi_b", 12'hB80, 32'd1);
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'h320, 32'h0);
        peek("wrap_lo_a", 12'hB00, 32'hFFFF_FFFF);
        idle();
        peek("wrap_lo_b", 12'hB00, 32'd0);
        peek("wrap_hi_b", 12'hB80, 32'd0);

        setin(OP_ECALL, 2'b00, 1'b0, 12'h000, 32'd0, 32'h444, 32'd0);
        cyc();
        peek("mepc_ecall", 12'h341, 32'h444);
        peek("mcause_ecall", 12'h342, 32'd11);
        setin(OP_ECALL, 2'b00, 1'b0, 12'h000, 32'd0, 32'h448, 32'd0);
        #3;
        rst = 1'b1;
        #1;
        peek("rst_mepc", 12'h341, 32'd0);
        peek("rst_mcause", 12'h342, 32'd0);
        peek("rst_mstatus2", 12'h300, 32'h0000_1800);
        chk("rst_vld2", 32'(intrpt_vld), 32'd0);
        @(posedge clk);
        m_reset();
        #1;
        rst = 1'b0;

        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 15);
            setin(OP_WRITE, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 12'($urandom) : atab[$urandom_range(0, 21)],
                  $urandom, $urandom, $urandom);
            if (r == 10) op = OP_ECALL;
            else if (r == 11) op = OP_EBREAK;
            else if (r == 12) op = OP_MRET;
            else if (r == 13) op = OP_INTRPT;
            else if (r == 14) op = OP_TRAP;
            else if (r == 15) op = OP_WFI;
            plat = 4'($urandom_range(0, 15));
            ext  = 1'($urandom_range(0, 1));
            iret = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
